// File: rtl/platform_x_gen.sv
// platform_x_gen: per-platform X position generator with LFSR respawn and bouncing movers
// Ports:
//   clk      - system clock
//   rst      - synchronous active-low reset
//   state    - game state; the block only acts when state == PLAY_STATE
//   score    - current score; above SCORE_THRESH masked channels move
//   y_bus    - platform Y positions, channel i at [i*YW +: YW]
//   x_bus    - platform X positions, channel i at [i*XW +: XW]
//   dir_bus  - per-channel direction (1 = moving left)
//   respawn  - registered one-cycle pulse per channel on respawn
module platform_x_gen #(
    parameter int                  NUM_PLAT     = 10,
    parameter int                  XW           = 9,
    parameter int                  YW           = 9,
    parameter logic [XW-1:0]       TAPS         = 9'h110,
    parameter logic [XW-1:0]       SEED_BASE    = 9'h0D1,
    parameter logic [XW-1:0]       SEED_STRIDE  = 9'h05B,
    parameter int                  X_MIN        = 0,
    parameter int                  X_MAX        = 479,
    parameter int                  Y_LIMIT      = 479,
    parameter int                  PLAY_STATE   = 2,
    parameter int                  SCORE_THRESH = 5000,
    parameter logic [NUM_PLAT-1:0] MOVE_MASK    = 10'b1010101010,
    parameter logic [NUM_PLAT-1:0] DIR_INIT     = 10'b1010110010,
    parameter int                  STEP         = 1,
    parameter int                  MOVE_DIV     = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             state,
    input  logic [13:0]            score,
    input  logic [NUM_PLAT*YW-1:0] y_bus,
    output logic [NUM_PLAT*XW-1:0] x_bus,
    output logic [NUM_PLAT-1:0]    dir_bus,
    output logic [NUM_PLAT-1:0]    respawn
);
    localparam int PW = MOVE_DIV > 1 ? $clog2(MOVE_DIV) : 1;

    function automatic logic [XW-1:0] seed_of(input int i);
        logic [XW-1:0] s;
        s = SEED_BASE ^ XW'(i * SEED_STRIDE);
        return s == '0 ? XW'(1) : s;
    endfunction

    // Values past the right bound are halved, which always lands in range
    // because X_MAX >= 2^(XW-1)-1.
    function automatic logic [XW-1:0] fold(input logic [XW-1:0] c);
        return ({1'b0, c} <= (XW+1)'(X_MAX)) ? c : c >> 1;
    endfunction

    logic          active, tick, fast;
    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        active = state == 2'(PLAY_STATE);
        fast   = score > 14'(SCORE_THRESH);
        tick   = active && pre_q == PW'(MOVE_DIV - 1);
        pre_d  = (!active || tick) ? '0 : pre_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        pre_q <= !rst ? '0 : pre_d;
    end

    for (genvar i = 0; i < NUM_PLAT; i++) begin : g_ch
        localparam logic [XW-1:0] SEED = seed_of(i);
        logic [XW-1:0] lfsr_q, lfsr_d, x_q, x_d, nxt;
        logic [XW:0]   up;
        logic          dir_q, dir_d, resp_q, resp_d, hit, mv, top, bot;

        always_comb begin
            // An all-zero LFSR would lock up, so it reloads its seed instead.
            nxt    = lfsr_q == '0 ? SEED : {lfsr_q[XW-2:0], ^(lfsr_q & TAPS)};
            up     = {1'b0, x_q} + (XW+1)'(STEP);
            top    = up >= (XW+1)'(X_MAX);
            bot    = {1'b0, x_q} <= (XW+1)'(X_MIN + STEP);
            hit    = active && y_bus[i*YW +: YW] > YW'(Y_LIMIT);
            mv     = fast && MOVE_MASK[i] && tick;
            lfsr_d = hit ? nxt : lfsr_q;
            resp_d = hit;
            x_d    = x_q;
            dir_d  = dir_q;
            if (hit) begin
                x_d   = fold(nxt);
                dir_d = DIR_INIT[i];
            end else if (mv && !dir_q) begin
                x_d   = top ? XW'(X_MAX) : up[XW-1:0];
                dir_d = top;
            end else if (mv) begin
                x_d   = bot ? XW'(X_MIN) : x_q - XW'(STEP);
                dir_d = !bot;
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                lfsr_q <= SEED;
                x_q    <= fold(SEED);
                dir_q  <= DIR_INIT[i];
                resp_q <= 1'b0;
            end else begin
                lfsr_q <= lfsr_d;
                x_q    <= x_d;
                dir_q  <= dir_d;
                resp_q <= resp_d;
            end
        end

        assign x_bus[i*XW +: XW] = x_q;
        assign dir_bus[i]        = dir_q;
        assign respawn[i]        = resp_q;
    end
endmodule

// File: tb/tb_platform_x_gen.sv
// tb_platform_x_gen: scoreboard and vector checks for platform_x_gen
module tb_platform_x_gen;
    typedef struct {
        logic [89:0] x;
        logic [9:0]  d;
        logic [9:0]  r;
    } exp_t;

    typedef struct {
        logic [1:0]  s;
        logic [13:0] c;
        logic [8:0]  y0;
        logic [8:0]  ex;
        logic        er;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0, rst4 = 1'b0;
    logic [1:0]  st = 2'd0, st4 = 2'd0;
    logic [13:0] sc = 14'd0, sc4 = 14'd6000;
    logic [89:0] yb = '0, yb4 = '0;
    logic [89:0] xb, xb4;
    logic [9:0]  db, rb, db4, rb4;
    logic [9:0]  mask_v  = 10'b1010101010;
    logic [9:0]  dinit_v = 10'b1010110010;

    int   checks = 0, failures = 0;
    int   m_l[10], m_x[10], m_d[10], m_r[10], m_p;
    exp_t sbq[$];

    always #5 clk = ~clk;

    platform_x_gen dut (.clk(clk), .rst(rst), .state(st), .score(sc), .y_bus(yb),
                        .x_bus(xb), .dir_bus(db), .respawn(rb));

    platform_x_gen #(.MOVE_DIV(4)) dut4 (.clk(clk), .rst(rst4), .state(st4), .score(sc4),
                        .y_bus(yb4), .x_bus(xb4), .dir_bus(db4), .respawn(rb4));

    task automatic chk(input string n, input logic [89:0] a, input logic [89:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endtask

    function automatic int seed(input int i);
        int s;
        s = (209 ^ (i * 91)) & 511;
        return s == 0 ? 1 : s;
    endfunction

    function automatic int fold(input int c);
        return c > 479 ? c / 2 : c;
    endfunction

    function automatic int lnext(input int l, input int i);
        if (l == 0) return seed(i);
        return ((l * 2) & 511) | (((l >> 8) ^ (l >> 4)) & 1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 10; i++) begin
            m_l[i] = seed(i);
            m_x[i] = fold(seed(i));
            m_d[i] = int'(dinit_v[i]);
            m_r[i] = 0;
        end
        m_p = 0;
    endtask

    task automatic model_step(input logic [1:0] s, input logic [13:0] c, input logic [89:0] y);
        int yi;
        for (int i = 0; i < 10; i++) m_r[i] = 0;
        if (s != 2'd2) begin
            m_p = 0;
            return;
        end
        for (int i = 0; i < 10; i++) begin
            yi = int'(y[i*9 +: 9]);
            if (yi > 479) begin
                m_l[i] = lnext(m_l[i], i);
                m_x[i] = fold(m_l[i]);
                m_d[i] = int'(dinit_v[i]);
                m_r[i] = 1;
            end else if (c > 5000 && mask_v[i]) begin
                if (m_d[i] == 0) begin
                    if (m_x[i] + 1 >= 479) begin m_x[i] = 479; m_d[i] = 1; end
                    else m_x[i] = m_x[i] + 1;
                end else begin
                    if (m_x[i] <= 1) begin m_x[i] = 0; m_d[i] = 0; end
                    else m_x[i] = m_x[i] - 1;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [1:0] s, input logic [13:0] c, input logic [89:0] y);
        exp_t e;
        @(negedge clk);
        rst = r; st = s; sc = c; yb = y;
        if (!r) model_reset();
        else model_step(s, c, y);
        for (int i = 0; i < 10; i++) begin
            e.x[i*9 +: 9] = 9'(m_x[i]);
            e.d[i] = m_d[i][0];
            e.r[i] = m_r[i][0];
        end
        sbq.push_back(e);
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        chk("sb_x", xb, e.x);
        chk("sb_dir", 90'(db), 90'(e.d));
        chk("sb_resp", 90'(rb), 90'(e.r));
    endtask

    task automatic step4(input logic r, input logic [1:0] s);
        @(negedge clk);
        rst4 = r; st4 = s;
        @(posedge clk);
        #1;
    endtask

    vec_t vt[10];
    int   first;

    initial begin
        vt[0] = '{2'd0, 14'd100,  9'd480, 9'd209, 1'b0};
        vt[1] = '{2'd2, 14'd100,  9'd479, 9'd209, 1'b0};
        vt[2] = '{2'd2, 14'd100,  9'd480, 9'd419, 1'b1};
        vt[3] = '{2'd2, 14'd100,  9'd480, 9'd327, 1'b1};
        vt[4] = '{2'd2, 14'd100,  9'd0,   9'd327, 1'b0};
        vt[5] = '{2'd1, 14'd100,  9'd511, 9'd327, 1'b0};
        vt[6] = '{2'd2, 14'd100,  9'd511, 9'd143, 1'b1};
        vt[7] = '{2'd2, 14'd6000, 9'd0,   9'd143, 1'b0};
        vt[8] = '{2'd2, 14'd6000, 9'd480, 9'd286, 1'b1};
        vt[9] = '{2'd2, 14'd100,  9'd480, 9'd60,  1'b1};

        // reset values, then idle hold in a non-play state
        step(0, 0, 0, '0);
        step(0, 0, 0, '0);
        chk("rst_x0", 90'(xb[8:0]), 90'(209));
        chk("rst_dir", 90'(db), 90'(10'b1010110010));
        chk("rst_resp", 90'(rb), 90'(0));
        for (int k = 0; k < 20; k++) step(1, 0, 14'd9000, {10{9'd480}});
        chk("idle_x0", 90'(xb[8:0]), 90'(209));

        // channel-0 respawn vectors
        step(0, 0, 0, '0);
        for (int k = 0; k < 10; k++) begin
            step(1, vt[k].s, vt[k].c, 90'(vt[k].y0));
            chk($sformatf("vec%0d_x0", k), 90'(xb[8:0]), 90'(vt[k].ex));
            chk($sformatf("vec%0d_r0", k), 90'(rb[0]), 90'(vt[k].er));
        end

        // full LFSR period on channel 0
        step(0, 0, 0, '0);
        first = 0;
        for (int k = 1; k <= 511; k++) begin
            step(1, 2, 14'd100, 90'(480));
            chk("sweep_range", 90'(xb[8:0] > 9'd479), 90'(0));
            if (first == 0 && xb[8:0] == 9'd209) first = k;
        end
        chk("sweep_period", 90'(first), 90'(511));

        // bounce of channel 1 at both limits
        step(0, 0, 0, '0);
        for (int k = 1; k <= 620; k++) begin
            step(1, 2, 14'd5001, '0);
            if (k == 137) begin chk("b137_x", 90'(xb[17:9]), 90'(1));   chk("b137_d", 90'(db[1]), 90'(1)); end
            if (k == 138) begin chk("b138_x", 90'(xb[17:9]), 90'(0));   chk("b138_d", 90'(db[1]), 90'(0)); end
            if (k == 139) begin chk("b139_x", 90'(xb[17:9]), 90'(1));   chk("b139_d", 90'(db[1]), 90'(0)); end
            if (k == 616) begin chk("b616_x", 90'(xb[17:9]), 90'(478)); chk("b616_d", 90'(db[1]), 90'(0)); end
            if (k == 617) begin chk("b617_x", 90'(xb[17:9]), 90'(479)); chk("b617_d", 90'(db[1]), 90'(1)); end
            if (k == 618) begin chk("b618_x", 90'(xb[17:9]), 90'(478)); chk("b618_d", 90'(db[1]), 90'(1)); end
        end
        chk("mask0_static", 90'(xb[8:0]), 90'(209));

        // respawn beats a move tick; threshold score is static
        step(0, 0, 0, '0);
        for (int k = 0; k < 150; k++) step(1, 2, 14'd6000, '0);
        chk("pri_pre_d1", 90'(db[1]), 90'(0));
        step(1, 2, 14'd6000, 90'(480) << 9);
        chk("pri_r1", 90'(rb[1]), 90'(1));
        chk("pri_d1", 90'(db[1]), 90'(1));
        chk("pri_x1", 90'(xb[17:9]), 90'(276));
        for (int k = 0; k < 10; k++) step(1, 2, 14'd5000, '0);
        chk("thresh_x1", 90'(xb[17:9]), 90'(276));

        // prescaled movement, gating and mid-game reset
        step4(0, 2);
        step4(0, 2);
        for (int k = 0; k < 3; k++) step4(1, 2);
        chk("div_3", 90'(xb4[17:9]), 90'(138));
        step4(1, 2);
        chk("div_4", 90'(xb4[17:9]), 90'(137));
        for (int k = 0; k < 3; k++) step4(1, 2);
        chk("div_7", 90'(xb4[17:9]), 90'(137));
        step4(1, 2);
        chk("div_8", 90'(xb4[17:9]), 90'(136));
        step4(1, 2);
        step4(1, 2);
        step4(1, 1);
        step4(1, 1);
        chk("div_frz", 90'(xb4[17:9]), 90'(136));
        for (int k = 0; k < 3; k++) step4(1, 2);
        chk("div_ret3", 90'(xb4[17:9]), 90'(136));
        step4(1, 2);
        chk("div_ret4", 90'(xb4[17:9]), 90'(135));
        step4(0, 2);
        chk("div_rst_x", 90'(xb4[17:9]), 90'(138));
        chk("div_rst_d", 90'(db4), 90'(10'b1010110010));
        chk("div_rst_r", 90'(rb4), 90'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
